// File: rtl/megadrive_save_pkg.sv
// megadrive_save_pkg: shared dirty-FSM state encoding and read-tag types for the backup-RAM arbiter
package megadrive_save_pkg;
  typedef enum logic [3:0] {
    CLEAN    = 4'b0001,
    DIRTY    = 4'b0010,
    SAVE_REQ = 4'b0100,
    SAVING   = 4'b1000
  } dirty_state_e;
  localparam logic SRC_EE = 1'b0;
  localparam logic SRC_HS = 1'b1;
  typedef struct packed {
    logic v;
    logic src;
  } rd_tag_t;
endpackage

// File: rtl/save_dirty_tracker.sv
// save_dirty_tracker: tracks unsaved EEPROM writes and raises save_req after a quiet period
module save_dirty_tracker
  import megadrive_save_pkg::*;
#(
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] TIMEOUT = 24'd4000000
) (
  input  logic clk,
  input  logic rst,
  input  logic ee_wr,
  input  logic rd_grant,
  input  logic save_ack,
  output logic save_req,
  output logic dirty
);
  dirty_state_e state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic redirty_q, redirty_d;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    redirty_d = redirty_q;
    case (state_q)
      CLEAN: begin
        state_d = ee_wr ? DIRTY : CLEAN;
        timer_d = ee_wr ? '0 : timer_q;
      end
      DIRTY: begin
        timer_d = ee_wr ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
        state_d = (!ee_wr && timer_q == TIMEOUT - 1'b1) ? SAVE_REQ : DIRTY;
      end
      SAVE_REQ: state_d = save_ack ? CLEAN : rd_grant ? SAVING : SAVE_REQ;
      SAVING: begin
        redirty_d = save_ack ? 1'b0 : redirty_q | ee_wr;
        state_d = !save_ack ? SAVING : (redirty_q || ee_wr) ? DIRTY : CLEAN;
        timer_d = save_ack ? '0 : timer_q;
      end
      default: state_d = CLEAN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAN;
      timer_q <= '0;
      redirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      redirty_q <= redirty_d;
    end
  end
  assign save_req = state_q == SAVE_REQ;
  assign dirty = state_q != CLEAN;
endmodule

// File: rtl/eeprom_bram_arbiter.sv
// eeprom_bram_arbiter: shares one backup BRAM between the EEPROM core (priority) and the host port
module eeprom_bram_arbiter
  import megadrive_save_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int RD_LAT = 2,
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] TIMEOUT = 24'd4000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ee_addr,
  input  logic [DW-1:0] ee_d,
  input  logic          ee_wr,
  input  logic          ee_rd,
  output logic [DW-1:0] ee_q,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_d,
  output logic          hs_ack,
  output logic [DW-1:0] hs_q,
  output logic          hs_rvalid,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_d,
  output logic          bram_we,
  input  logic [DW-1:0] bram_q,
  output logic          save_req,
  input  logic          save_ack,
  output logic          dirty
);
  localparam int D = RD_LAT > 1 ? RD_LAT - 1 : 1;
  logic ee_acc, hs_gnt;
  rd_tag_t [D:0] chain;
  rd_tag_t [D-1:0] tag_q;
  rd_tag_t tag_out;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] d_q, ee_q_q, ee_q_d, hs_q_q, hs_q_d;
  logic rv_q, rv_d;
  always_comb begin
    ee_acc = !rst && (ee_wr || ee_rd);
    hs_gnt = !rst && !ee_acc && hs_req;
    hs_ack = hs_gnt;
    bram_we = ee_acc ? ee_wr : hs_gnt && hs_we;
    bram_addr = ee_acc ? ee_addr : hs_gnt ? hs_addr : addr_q;
    bram_d = ee_acc ? ee_d : hs_gnt ? hs_d : d_q;
    chain[0] = '{v: (ee_acc && !ee_wr) || (hs_gnt && !hs_we), src: ee_acc ? SRC_EE : SRC_HS};
    chain[D:1] = tag_q;
    tag_out = chain[RD_LAT-1];
    ee_q_d = (tag_out.v && tag_out.src == SRC_EE) ? bram_q : ee_q_q;
    hs_q_d = (tag_out.v && tag_out.src == SRC_HS) ? bram_q : hs_q_q;
    rv_d = tag_out.v && tag_out.src == SRC_HS;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      d_q <= '0;
      tag_q <= '0;
      ee_q_q <= '0;
      hs_q_q <= '0;
      rv_q <= 1'b0;
    end else begin
      addr_q <= bram_addr;
      d_q <= bram_d;
      tag_q <= chain[D-1:0];
      ee_q_q <= ee_q_d;
      hs_q_q <= hs_q_d;
      rv_q <= rv_d;
    end
  end
  assign ee_q = ee_q_q;
  assign hs_q = hs_q_q;
  assign hs_rvalid = rv_q;
  save_dirty_tracker #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_dirty (
    .clk(clk),
    .rst(rst),
    .ee_wr(ee_acc && ee_wr),
    .rd_grant(hs_gnt && !hs_we),
    .save_ack(save_ack),
    .save_req(save_req),
    .dirty(dirty)
  );
endmodule
